// File: rtl/rr_arb8_if.sv
// Request/grant bundle between the requesters and the rr_arb8 arbiter.
// master drives req/done, slave (the arbiter) drives the grant side.
interface rr_arb8_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arb8.sv
// 8-way round-robin arbiter with hold limit and timeout pulse.
// Define FIXED_PRIO_EN for fixed priority (highest index wins).
module rr_arb8 #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 15
) (
  input  logic     clk,
  input  logic     rst_n,
  rr_arb8_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [N-1:0]     gnt_q, gnt_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic             valid_q, valid_n;
  logic             to_q, to_n;
  logic [7:0]       hold_q, hold_n;
  logic [IDX_W-1:0] win;
  logic             rel;

`ifndef FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr_q, ptr_n;

  // Descending scan so the closest index after ptr is written last.
  always_comb begin
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.req[ptr_q + IDX_W'(k)]) begin
        win = ptr_q + IDX_W'(k);
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.req[k]) begin
        win = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    idx_n   = idx_q;
    valid_n = valid_q;
    hold_n  = hold_q;
    to_n    = 1'b0;
    rel     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          state_n = GRANT;
          gnt_n   = N'(1) << win;
          idx_n   = win;
          valid_n = 1'b1;
          hold_n  = 8'd1;
        end
      end
      GRANT: begin
        if (bus.done) begin
          rel = 1'b1;
        end else if (!bus.req[idx_q]) begin
          rel = 1'b1;
        end else if (hold_q == 8'(MAX_HOLD)) begin
          rel  = 1'b1;
          to_n = 1'b1;
        end else begin
          hold_n = hold_q + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (rel) begin
      state_n = IDLE;
      gnt_n   = '0;
      idx_n   = '0;
      valid_n = 1'b0;
      hold_n  = '0;
    end
  end

`ifndef FIXED_PRIO_EN
  always_comb begin
    ptr_n = ptr_q;
    if (rel) begin
      ptr_n = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_n;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state   <= state_n;
      gnt_q   <= gnt_n;
      idx_q   <= idx_n;
      valid_q <= valid_n;
      to_q    <= to_n;
      hold_q  <= hold_n;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = to_q;

endmodule
